uart_receiver: RTL and testbench
================================

# uart_receiver

Receive-side counterpart of the UART transmitter in the serial-protocol controller. It deserialises one 11-bit frame from the serial line: start bit 0, eight data bits MSB first, even parity (parity bit = XOR of the data bits), stop bit 1. The line idles high. The block synchronises the line, samples each bit at mid-bit, checks parity and framing, and presents the byte with a one-cycle valid pulse. It sits between the pad or loopback line and the protocol-select mux.

## Interface
Parameters:
- CLKS_PER_BIT, 1: clock cycles per serial bit; minimum 1. The default matches the one-bit-per-clock transmitter.
- SYNC_STAGES, 2: input synchroniser depth; minimum 2.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- rx_in  in  1  serial line, asynchronous to clk
- rx_data_out  out  8  last received byte; held until the next frame completes
- rx_valid  out  1  one-cycle pulse when a frame completes, whether errored or not
- parity_err  out  1  parity mismatch on the last frame; updated with rx_valid
- frame_err  out  1  stop bit was 0 on the last frame; updated with rx_valid
- busy  out  1  high from confirmed start bit until the block returns to IDLE

## Operation
- Reset values:
  - rx_data_out=0x00; rx_valid, parity_err, frame_err, busy = 0.
  - Synchroniser flops = 1; state = IDLE; bit and cycle counters = 0.
- Sampling:
  - H = (CLKS_PER_BIT-1)/2, integer division.
  - The cycle counter is $clog2(CLKS_PER_BIT+1) bits wide.
  - The bit counter counts data bits 7 down to 0.
- IDLE:
  - busy=0.
  - On synchronised line = 0: if H=0, this is the start sample, go to DATA; otherwise load H and go to START.
- START:
  - Count down H cycles, then re-sample.
  - If 0, go to DATA. If 1, it was a glitch: return to IDLE with no outputs.
  - busy rises on the confirmed start sample.
- DATA:
  - Sample every CLKS_PER_BIT cycles and shift in MSB first.
  - After bit 0, go to PARITY.
- PARITY: sample once, compare with the XOR of the 8 shifted bits, then go to STOP.
- STOP:
  - Sample once. Load rx_data_out, parity_err and frame_err, and pulse rx_valid.
  - Stop=1: go to IDLE on the same edge.
  - Stop=0: go to WAIT_HIGH.
- WAIT_HIGH:
  - busy stays 1. Stay until the synchronised line = 1, then go to IDLE.
  - This prevents a break or a stuck-low line from re-triggering.
- Completed frames always update all three result outputs: data is delivered even when errors are flagged.
- Reset asserted mid-frame: immediate return to reset values, no rx_valid, partial byte discarded.

## Timing
- Let S be the first clk edge at which the first synchroniser flop captures the start bit's 0.
- Frame bit i (0=start … 10=stop) is sampled at edge S + SYNC_STAGES + H + i·CLKS_PER_BIT.
- rx_valid and the result outputs are registered and visible after the stop-sample edge; rx_valid is high for exactly one cycle.
- With defaults: start sampled at S+2, stop at S+12, rx_valid high in the cycle after edge S+12.
- Back-to-back frames: the block is in IDLE on the cycle after a good stop sample. A start bit immediately following the stop bit is caught with zero gap.
- No backpressure: the consumer must accept on rx_valid, and the next frame overwrites the outputs.

## Structure
- Shared package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - DATA_BITS=8, FRAME_BITS=11;
  - even-parity function, also used by the transmitter.
- Sub-module uart_rx_sync: SYNC_STAGES-deep flop chain with async preset to 1, parameterised depth. The FSM and counters live in uart_receiver.

## Test plan
- Defaults, transmitter loopback sends 0xA5 → rx_data_out=0xA5, one rx_valid pulse at S+13, parity_err=0, frame_err=0.
- Hand-driven frame with data 0x3C and parity bit forced to 1 → rx_data_out=0x3C, parity_err=1, frame_err=0, one rx_valid pulse.
- Frame 0x81 with stop bit 0, line held low 20 cycles, then high → frame_err=1, single rx_valid, busy high until line high plus synchroniser delay, no second frame.
- CLKS_PER_BIT=16: 3-cycle low glitch on idle line → no rx_valid, busy stays 0. Then a valid 0x5A frame → 0x5A received.
- Back-to-back frames 0x00 then 0xFF with no idle gap → two rx_valid pulses exactly 11 cycles apart, data 0x00 then 0xFF, no errors.
- rst asserted at data bit 4 of a frame → all outputs at reset values immediately, no rx_valid. After deassertion, the next frame 0x42 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, frame geometry and the
// even-parity helper also used by the transmitter.
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous serial line; flops preset to
// the idle-high level so reset never looks like a start bit.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_sync
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  assign chain_d = {chain_q[STAGES-2:0], rx_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain_q <= '1;
    else     chain_q <= chain_d;
  end

  assign rx_sync = chain_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 8 data bits MSB first, even parity, one stop bit.
// Samples each bit at mid-bit and reports the byte with a one-cycle valid.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data_out,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

  logic                 rx_s;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 tick;

  uart_rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .rx_in   (rx_in),
    .rx_sync (rx_s)
  );

  // Counter is loaded with the wait length and the sample is taken as it reaches 1.
  assign tick = (cnt_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          if (HALF == '0) begin
            state_d = DATA;
            cnt_d   = FULL;
            bit_d   = BW'(DATA_BITS - 1);
          end else begin
            state_d = START;
            cnt_d   = HALF;
          end
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            state_d = DATA;
            cnt_d   = FULL;
            bit_d   = BW'(DATA_BITS - 1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {shift_q[DATA_BITS-2:0], rx_s};
          cnt_d   = FULL;
          if (bit_q == '0) state_d = PARITY;
          else             bit_d   = bit_q - BW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          par_bad_d = rx_s ^ even_parity(shift_q);
          cnt_d     = FULL;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          data_d  = shift_q;
          perr_d  = par_bad_q;
          ferr_d  = ~rx_s;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = rx_s ? IDLE : WAIT_HIGH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WAIT_HIGH: begin
        // A stuck-low line must not be mistaken for a new start bit.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != START);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign rx_data_out = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign frame_err   = ferr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench: one receiver at one clock per bit, one at 16 clocks per bit.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b;
  logic [7:0] data_a, data_b;
  logic       vld_a, vld_b, perr_a, perr_b, ferr_a, ferr_b, busy_a, busy_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;

  int         na = 0;
  logic [7:0] cap_d [0:31];
  logic       cap_p [0:31];
  logic       cap_f [0:31];
  int         cap_c [0:31];

  int         nb = 0;
  int         busy_b_cnt = 0;
  logic [7:0] last_db;
  logic       last_pb, last_fb;
  int         last_cb;

  int n0;

  uart_receiver #(.CLKS_PER_BIT(1), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .rst(rst), .rx_in(rx_a), .rx_data_out(data_a), .rx_valid(vld_a),
    .parity_err(perr_a), .frame_err(ferr_a), .busy(busy_a)
  );

  uart_receiver #(.CLKS_PER_BIT(16), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .rst(rst), .rx_in(rx_b), .rx_data_out(data_b), .rx_valid(vld_b),
    .parity_err(perr_b), .frame_err(ferr_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld_a) begin
      if (na < 32) begin
        cap_d[na] <= data_a;
        cap_p[na] <= perr_a;
        cap_f[na] <= ferr_a;
        cap_c[na] <= cyc;
      end
      na <= na + 1;
    end
  end

  always @(negedge clk) begin
    if (vld_b) begin
      last_db <= data_b;
      last_pb <= perr_b;
      last_fb <= ferr_b;
      last_cb <= cyc;
      nb      <= nb + 1;
    end
    if (busy_b) busy_b_cnt <= busy_b_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic par,
                      input logic stp, input int cpb);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int k = 0; k < 8; k++) f[1+k] = d[7-k];
    f[9]  = par;
    f[10] = stp;
    start_cyc = cyc;
    for (int i = 0; i < 11; i++) begin
      if (which == 0) rx_a = f[i];
      else            rx_b = f[i];
      repeat (cpb) @(negedge clk);
    end
  endtask

  initial begin
    logic [10:0] fr;
    rst  = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    wait_cyc(3);
    chk("reset_data", {24'h0, data_a}, 32'h00);
    chk("reset_flags", {28'h0, vld_a, perr_a, ferr_a, busy_a}, 32'h0);
    chk("reset_b", {20'h0, data_b, vld_b, perr_b, ferr_b, busy_b}, 32'h0);
    rst = 1'b0;
    wait_cyc(3);

    // Good frame 0xA5 (parity 0)
    n0 = na;
    send(0, 8'hA5, 1'b0, 1'b1, 1);
    wait_cyc(4);
    chk("a5_count", na - n0, 1);
    chk("a5_data", {24'h0, cap_d[n0]}, 32'hA5);
    chk("a5_errs", {30'h0, cap_p[n0], cap_f[n0]}, 32'h0);
    chk("a5_time", cap_c[n0], start_cyc + 13);
    chk("a5_hold", {24'h0, data_a}, 32'hA5);
    chk("a5_busy", {31'h0, busy_a}, 32'h0);

    // 0x3C with wrong parity bit
    n0 = na;
    send(0, 8'h3C, 1'b1, 1'b1, 1);
    wait_cyc(4);
    chk("3c_count", na - n0, 1);
    chk("3c_data", {24'h0, cap_d[n0]}, 32'h3C);
    chk("3c_perr", {31'h0, cap_p[n0]}, 32'h1);
    chk("3c_ferr", {31'h0, cap_f[n0]}, 32'h0);

    // 0x81 with stop bit 0, line low 20 cycles
    n0 = na;
    send(0, 8'h81, 1'b0, 1'b0, 1);
    wait_cyc(19);
    chk("81_count", na - n0, 1);
    chk("81_data", {24'h0, data_a}, 32'h81);
    chk("81_errs", {30'h0, parity_err_a(), ferr_a}, 32'h1);
    chk("81_busy_low", {31'h0, busy_a}, 32'h1);
    rx_a = 1'b1;
    wait_cyc(2);
    chk("81_busy_sync", {31'h0, busy_a}, 32'h1);
    wait_cyc(1);
    chk("81_busy_drop", {31'h0, busy_a}, 32'h0);
    wait_cyc(20);
    chk("81_no_second", na - n0, 1);

    // Back-to-back 0x00 then 0xFF
    n0 = na;
    send(0, 8'h00, 1'b0, 1'b1, 1);
    send(0, 8'hFF, 1'b0, 1'b1, 1);
    wait_cyc(4);
    chk("b2b_count", na - n0, 2);
    chk("b2b_data0", {24'h0, cap_d[n0]}, 32'h00);
    chk("b2b_data1", {24'h0, cap_d[n0+1]}, 32'hFF);
    chk("b2b_gap", cap_c[n0+1] - cap_c[n0], 11);
    chk("b2b_errs", {28'h0, cap_p[n0], cap_f[n0], cap_p[n0+1], cap_f[n0+1]}, 32'h0);

    // Reset during data bit 4 of 0x42
    n0 = na;
    fr[0] = 1'b0;
    for (int k = 0; k < 8; k++) fr[1+k] = 8'h42 >> (7 - k);
    for (int i = 0; i < 4; i++) begin
      rx_a = fr[i];
      @(negedge clk);
    end
    rx_a = fr[4];
    #2;
    chk("rst_busy_before", {31'h0, busy_a}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_data", {24'h0, data_a}, 32'h00);
    chk("rst_flags", {28'h0, vld_a, perr_a, ferr_a, busy_a}, 32'h0);
    rx_a = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    chk("rst_no_valid", na - n0, 0);
    send(0, 8'h42, 1'b0, 1'b1, 1);
    wait_cyc(4);
    chk("42_count", na - n0, 1);
    chk("42_data", {24'h0, cap_d[n0]}, 32'h42);
    chk("42_errs", {30'h0, cap_p[n0], cap_f[n0]}, 32'h0);

    // 16 clocks per bit: short glitch, then 0x5A
    n0 = nb;
    rx_b = 1'b0;
    wait_cyc(3);
    rx_b = 1'b1;
    wait_cyc(40);
    chk("glitch_no_valid", nb - n0, 0);
    chk("glitch_no_busy", busy_b_cnt, 0);
    send(1, 8'h5A, 1'b0, 1'b1, 16);
    wait_cyc(4);
    chk("5a_count", nb - n0, 1);
    chk("5a_data", {24'h0, last_db}, 32'h5A);
    chk("5a_errs", {30'h0, last_pb, last_fb}, 32'h0);
    chk("5a_time", last_cb, start_cyc + 170);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic parity_err_a();
    return perr_a;
  endfunction

endmodule
